// File: rtl/forward_history_buffer.sv
// Shift history of the last FORWARDED_CLOCK_CYCLES enabled write-backs; the youngest entry matching the lookup drives forward_* with no added latency.
// Define FWD_HIT_COUNTER_EN to add hit_cnt_o, a saturating 16-bit count of enabled cycles that hit.
module forward_history_buffer #(
    parameter int DATA_WIDTH             = 4,
    parameter int KEY_WIDTH              = 2,
    parameter int HASH_ADR_WIDTH         = 2,
    parameter int NUMBER_OF_TABLES       = 2,
    parameter int FORWARDED_CLOCK_CYCLES = 2,
    localparam int TW = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1,
    localparam int CW = $clog2(FORWARDED_CLOCK_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      flush_i,
    input  logic                      wr_valid_i,
    input  logic [TW-1:0]             wr_table_i,
    input  logic [HASH_ADR_WIDTH-1:0] wr_hash_adr_i,
    input  logic [KEY_WIDTH-1:0]      wr_key_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic                      wr_updated_mem_i,
    input  logic [TW-1:0]             q_table_i,
    input  logic [HASH_ADR_WIDTH-1:0] q_hash_adr_i,
    output logic [HASH_ADR_WIDTH-1:0] forward_hash_adr_o,
    output logic [KEY_WIDTH-1:0]      forward_key_o,
    output logic [DATA_WIDTH-1:0]     forward_data_o,
    output logic                      forward_updated_mem_o,
    output logic                      forward_valid_o,
    output logic [CW-1:0]             fill_cnt_o
`ifdef FWD_HIT_COUNTER_EN
    ,
    output logic [15:0]               hit_cnt_o
`endif
);
    localparam int D = FORWARDED_CLOCK_CYCLES;

    typedef struct packed {
        logic                      valid;
        logic [TW-1:0]             tab;
        logic [HASH_ADR_WIDTH-1:0] adr;
        logic [KEY_WIDTH-1:0]      key;
        logic [DATA_WIDTH-1:0]     data;
        logic                      upd;
    } slot_t;

    slot_t [D-1:0] slots_q, slots_d;
    logic [CW-1:0] fill_q, fill_d;
    slot_t         hit_slot;
    logic          hit;

    always_comb begin
        slots_d = slots_q;
        if (clk_en) begin
            for (int k = D - 1; k > 0; k--) begin
                slots_d[k] = slots_q[k-1];
            end
            slots_d[0].valid = wr_valid_i;
            slots_d[0].tab   = wr_table_i;
            slots_d[0].adr   = wr_hash_adr_i;
            slots_d[0].key   = wr_key_i;
            slots_d[0].data  = wr_data_i;
            slots_d[0].upd   = wr_updated_mem_i;
        end
        // Flush wipes the history only; a write landing on the same edge survives.
        if (flush_i) begin
            for (int k = 0; k < D; k++) begin
                slots_d[k].valid = 1'b0;
            end
            if (clk_en) begin
                slots_d[0].valid = wr_valid_i;
            end
        end
        fill_d = '0;
        for (int k = 0; k < D; k++) begin
            fill_d = fill_d + CW'(slots_d[k].valid);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slots_q <= '0;
            fill_q  <= '0;
        end else begin
            slots_q <= slots_d;
            fill_q  <= fill_d;
        end
    end

    // Scan oldest to youngest so the lowest-index match overwrites any older one.
    always_comb begin
        hit      = 1'b0;
        hit_slot = '0;
        for (int k = D - 1; k >= 0; k--) begin
            if (slots_q[k].valid && slots_q[k].tab == q_table_i &&
                slots_q[k].adr == q_hash_adr_i) begin
                hit      = 1'b1;
                hit_slot = slots_q[k];
            end
        end
        forward_valid_o       = hit;
        forward_hash_adr_o    = hit_slot.adr;
        forward_key_o         = hit_slot.key;
        forward_data_o        = hit_slot.data;
        forward_updated_mem_o = hit_slot.upd;
    end

    assign fill_cnt_o = fill_q;

`ifdef FWD_HIT_COUNTER_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (flush_i) begin
            hit_cnt_d = '0;
        end else if (clk_en && hit && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt_o = hit_cnt_q;
`endif
endmodule

// File: tb/tb_forward_history_buffer.sv
// Bench for forward_history_buffer: queue-based history model checked every cycle, plus directed literal checks.
module tb_forward_history_buffer;
    localparam int DW = 4;
    localparam int KW = 2;
    localparam int AW = 2;
    localparam int TW = 1;
    localparam int D  = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          flush_i;
    logic          wr_valid_i;
    logic [TW-1:0] wr_table_i;
    logic [AW-1:0] wr_hash_adr_i;
    logic [KW-1:0] wr_key_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_updated_mem_i;
    logic [TW-1:0] q_table_i;
    logic [AW-1:0] q_hash_adr_i;
    logic [AW-1:0] forward_hash_adr_o;
    logic [KW-1:0] forward_key_o;
    logic [DW-1:0] forward_data_o;
    logic          forward_updated_mem_o;
    logic          forward_valid_o;
    logic [CW-1:0] fill_cnt_o;
`ifdef FWD_HIT_COUNTER_EN
    logic [15:0]   hit_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    forward_history_buffer dut (
        .clk                   (clk),
        .reset                 (reset),
        .clk_en                (clk_en),
        .flush_i               (flush_i),
        .wr_valid_i            (wr_valid_i),
        .wr_table_i            (wr_table_i),
        .wr_hash_adr_i         (wr_hash_adr_i),
        .wr_key_i              (wr_key_i),
        .wr_data_i             (wr_data_i),
        .wr_updated_mem_i      (wr_updated_mem_i),
        .q_table_i             (q_table_i),
        .q_hash_adr_i          (q_hash_adr_i),
        .forward_hash_adr_o    (forward_hash_adr_o),
        .forward_key_o         (forward_key_o),
        .forward_data_o        (forward_data_o),
        .forward_updated_mem_o (forward_updated_mem_o),
        .forward_valid_o       (forward_valid_o),
        .fill_cnt_o            (fill_cnt_o)
`ifdef FWD_HIT_COUNTER_EN
        ,
        .hit_cnt_o             (hit_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference: list of recorded writes, youngest first, at most D long.
    typedef struct {
        logic          v;
        logic [TW-1:0] t;
        logic [AW-1:0] a;
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        logic          u;
    } ent_t;

    ent_t hist[$];
    int   m_hcnt = 0;

    function automatic void mlook(input logic [TW-1:0] t, input logic [AW-1:0] a,
                                  output logic f, output ent_t e);
        f = 1'b0;
        e = '{v: 1'b0, t: '0, a: '0, k: '0, d: '0, u: 1'b0};
        foreach (hist[i]) begin
            if (!f && hist[i].v && hist[i].t == t && hist[i].a == a) begin
                f = 1'b1;
                e = hist[i];
            end
        end
    endfunction

    function automatic int mfill();
        int n = 0;
        foreach (hist[i]) if (hist[i].v) n++;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        logic f;
        ent_t e;
        ent_t nw;
        if (!reset) begin
            hist.delete();
            m_hcnt = 0;
        end else begin
            mlook(q_table_i, q_hash_adr_i, f, e);
            if (flush_i) m_hcnt = 0;
            else if (clk_en && f && m_hcnt < 65535) m_hcnt++;
            if (flush_i) foreach (hist[i]) hist[i].v = 1'b0;
            if (clk_en) begin
                nw.v = wr_valid_i; nw.t = wr_table_i; nw.a = wr_hash_adr_i;
                nw.k = wr_key_i;   nw.d = wr_data_i;  nw.u = wr_updated_mem_i;
                hist.push_front(nw);
                if (hist.size() > D) void'(hist.pop_back());
            end
        end
    end

    always @(negedge clk) begin : compare
        logic f;
        ent_t e;
        logic [31:0] act, exp;
        mlook(q_table_i, q_hash_adr_i, f, e);
        act = 32'({forward_valid_o, forward_hash_adr_o, forward_key_o, forward_data_o, forward_updated_mem_o});
        exp = 32'({f, e.a, e.k, e.d, e.u});
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL lookup t=%0t got %0h expected %0h", $time, act, exp);
        end
        checks++;
        if (32'(fill_cnt_o) !== 32'(mfill())) begin
            failures++;
            $display("FAIL fill t=%0t got %0d expected %0d", $time, fill_cnt_o, mfill());
        end
`ifdef FWD_HIT_COUNTER_EN
        checks++;
        if (32'(hit_cnt_o) !== 32'(m_hcnt)) begin
            failures++;
            $display("FAIL hit_cnt t=%0t got %0d expected %0d", $time, hit_cnt_o, m_hcnt);
        end
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic v, input logic [TW-1:0] t, input logic [AW-1:0] a,
                          input logic [KW-1:0] k, input logic [DW-1:0] d, input logic u);
        wr_valid_i = v; wr_table_i = t; wr_hash_adr_i = a;
        wr_key_i = k;   wr_data_i = d;  wr_updated_mem_i = u;
    endtask

    task automatic set_q(input logic [TW-1:0] t, input logic [AW-1:0] a);
        q_table_i = t;
        q_hash_adr_i = a;
        #1;
    endtask

    task automatic rand_inputs();
        clk_en  = ($urandom % 4) != 0;
        flush_i = ($urandom % 20) == 0;
        set_wr(1'($urandom), TW'($urandom), AW'($urandom), KW'($urandom),
               DW'($urandom), 1'($urandom));
        q_table_i    = TW'($urandom);
        q_hash_adr_i = AW'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        rand_inputs();
        repeat (3) begin
            cyc();
            rand_inputs();
            #1;
            chk("reset_valid", 32'(forward_valid_o), 32'd0);
            chk("reset_data", 32'({forward_hash_adr_o, forward_key_o, forward_data_o, forward_updated_mem_o}), 32'd0);
            chk("reset_fill", 32'(fill_cnt_o), 32'd0);
        end
        cyc();
        reset = 1'b1;
        clk_en = 1'b1;
        flush_i = 1'b0;
        set_wr(0, 0, 0, 0, 0, 0);
        set_q(0, 1);
        chk("post_reset_miss", 32'(forward_valid_o), 32'd0);

        // Single hit ages out after D enabled edges.
        set_wr(1, 0, 2, 1, 4'hA, 1);
        set_q(0, 2);
        cyc();
        set_wr(0, 0, 0, 0, 0, 0);
        #1;
        chk("single_valid", 32'(forward_valid_o), 32'd1);
        chk("single_key", 32'(forward_key_o), 32'd1);
        chk("single_data", 32'(forward_data_o), 32'hA);
        chk("single_upd", 32'(forward_updated_mem_o), 32'd1);
        chk("single_fill", 32'(fill_cnt_o), 32'd1);
        cyc();
        chk("single_age1", 32'(forward_valid_o), 32'd1);
        cyc();
        chk("single_gone", 32'(forward_valid_o), 32'd0);
        chk("single_fill0", 32'(fill_cnt_o), 32'd0);

        // Youngest wins; table must match.
        set_wr(1, 1, 3, 0, 4'd5, 1);
        cyc();
        set_wr(1, 1, 3, 0, 4'd9, 1);
        cyc();
        set_wr(0, 0, 0, 0, 0, 0);
        set_q(1, 3);
        chk("youngest_data", 32'(forward_data_o), 32'd9);
        chk("youngest_valid", 32'(forward_valid_o), 32'd1);
        set_q(0, 3);
        chk("table_mismatch", 32'(forward_valid_o), 32'd0);
        repeat (2) cyc();

        // clk_en low holds history and ignores writes.
        set_wr(1, 0, 1, 2, 4'd7, 1);
        cyc();
        clk_en = 1'b0;
        set_wr(1, 0, 1, 2, 4'd3, 1);
        repeat (5) cyc();
        set_q(0, 1);
        chk("hold_data", 32'(forward_data_o), 32'd7);
        chk("hold_fill", 32'(fill_cnt_o), 32'd1);

        // Flush with concurrent write keeps only the new write.
        clk_en = 1'b1;
        set_wr(1, 0, 1, 0, 4'd1, 1);
        cyc();
        set_wr(1, 0, 2, 0, 4'd2, 1);
        cyc();
        chk("full_fill", 32'(fill_cnt_o), 32'd2);
        flush_i = 1'b1;
        set_wr(1, 0, 0, 0, 4'hC, 1);
        cyc();
        flush_i = 1'b0;
        clk_en = 1'b0;
        set_wr(0, 0, 0, 0, 0, 0);
        chk("flush_fill", 32'(fill_cnt_o), 32'd1);
        set_q(0, 0);
        chk("flush_hit", 32'({forward_valid_o, forward_data_o}), 32'h1C);
        set_q(0, 2);
        chk("flush_miss2", 32'(forward_valid_o), 32'd0);
        set_q(0, 1);
        chk("flush_miss1", 32'(forward_valid_o), 32'd0);

        // Delete write still forwards, with updated_mem cleared.
        clk_en = 1'b1;
        set_wr(1, 0, 0, 0, 4'd0, 0);
        cyc();
        clk_en = 1'b0;
        set_wr(0, 0, 0, 0, 0, 0);
        set_q(0, 0);
        chk("delete_valid", 32'(forward_valid_o), 32'd1);
        chk("delete_upd", 32'(forward_updated_mem_o), 32'd0);

`ifdef FWD_HIT_COUNTER_EN
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("hcnt_flush0", 32'(hit_cnt_o), 32'd0);
        clk_en = 1'b1;
        set_wr(1, 0, 1, 0, 4'd5, 1);
        set_q(0, 1);
        cyc();
        chk("hcnt_first", 32'(hit_cnt_o), 32'd0);
        repeat (3) cyc();
        chk("hcnt_three", 32'(hit_cnt_o), 32'd3);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("hcnt_flush", 32'(hit_cnt_o), 32'd0);
        repeat (65540) cyc();
        chk("hcnt_sat", 32'(hit_cnt_o), 32'hFFFF);
`endif

        repeat (2000) begin
            cyc();
            rand_inputs();
        end
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
